// File: rtl/niosii_system_sysid_checker.sv
// niosii_system_sysid_checker: reads sysid ID/timestamp words and compares them to expected values
// Ports: clock, reset (async, active-high); start requests a check (IDLE only);
//   sysid_address/sysid_readdata drive the sysid slave; busy, done, id_match, ts_match,
//   id_value, ts_value and retry_count report the last check.
// Optional macro SYSID_CHECK_RETRY_EN: re-run a mismatching check up to MAX_RETRY times.
module niosii_system_sysid_checker #(
  parameter logic [31:0] EXPECTED_ID        = 32'd0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1457391355,
  parameter int          WAIT_CYCLES        = 2,
  parameter bit          AUTO_START         = 1'b1,
  parameter int          MAX_RETRY          = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        sysid_address,
  input  logic [31:0] sysid_readdata,
  output logic        busy,
  output logic        done,
  output logic        id_match,
  output logic        ts_match,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output logic [3:0]  retry_count
);
  typedef enum logic [2:0] {IDLE, RD_ID, RD_TS, COMPARE, DONE} state_t;
  state_t state, state_nx;
  logic [3:0] cnt;
  logic armed;
  logic last;
  logic retry;
  assign last = cnt == 4'(WAIT_CYCLES - 1);
`ifdef SYSID_CHECK_RETRY_EN
  logic [3:0] retries;
  assign retry = (id_value != EXPECTED_ID || ts_value != EXPECTED_TIMESTAMP) && retries < 4'(MAX_RETRY);
  assign retry_count = retries;
`else
  logic unused_max_retry;
  assign unused_max_retry = ^MAX_RETRY;
  assign retry = 1'b0;
  assign retry_count = 4'd0;
`endif
  assign sysid_address = state == RD_TS;
  assign busy = state inside {RD_ID, RD_TS, COMPARE};
  assign done = state == DONE;
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = IDLE;
    case (state)
      IDLE:    state_nx = (start || armed) ? RD_ID : IDLE;
      RD_ID:   state_nx = last ? RD_TS : RD_ID;
      RD_TS:   state_nx = last ? COMPARE : RD_TS;
      COMPARE: state_nx = retry ? RD_ID : DONE;
      default: state_nx = IDLE;
    endcase
  end
  // armed fires the single automatic check on the first edge after reset release
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      cnt <= 4'd0;
      armed <= AUTO_START;
      id_match <= 1'b0;
      ts_match <= 1'b0;
      id_value <= 32'd0;
      ts_value <= 32'd0;
`ifdef SYSID_CHECK_RETRY_EN
      retries <= 4'd0;
`endif
    end else begin
      armed <= 1'b0;
      cnt <= (state inside {RD_ID, RD_TS} && !last) ? cnt + 4'd1 : 4'd0;
      if (state == RD_ID && last) id_value <= sysid_readdata;
      if (state == RD_TS && last) ts_value <= sysid_readdata;
      if (state == IDLE && state_nx == RD_ID) begin
        id_match <= 1'b0;
        ts_match <= 1'b0;
`ifdef SYSID_CHECK_RETRY_EN
        retries <= 4'd0;
`endif
      end
      if (state == COMPARE) begin
        id_match <= id_value == EXPECTED_ID;
        ts_match <= ts_value == EXPECTED_TIMESTAMP;
`ifdef SYSID_CHECK_RETRY_EN
        if (retry) retries <= retries + 4'd1;
`endif
      end
    end
endmodule

// File: tb/tb_niosii_system_sysid_checker.sv
// tb_niosii_system_sysid_checker: randomized self-checking bench against a cycle-count reference model
module tb_niosii_system_sysid_checker;
  localparam logic [31:0] EXP_TS = 32'd1457391355;
`ifdef SYSID_CHECK_RETRY_EN
  localparam int RETRY_LIM = 3;
`else
  localparam int RETRY_LIM = 0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start [2];
  logic addr [2], busy [2], done_o [2], idm [2], tsm [2];
  logic [31:0] rd [2], id_v [2], ts_v [2], id_w [2], ts_w [2];
  logic [3:0] rc [2];
  int wc [2] = '{2, 1};
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  assign rd[0] = addr[0] ? ts_w[0] : id_w[0];
  assign rd[1] = addr[1] ? ts_w[1] : id_w[1];
  niosii_system_sysid_checker u0 (
    .clock(clk), .reset(reset), .start(start[0]), .sysid_address(addr[0]), .sysid_readdata(rd[0]),
    .busy(busy[0]), .done(done_o[0]), .id_match(idm[0]), .ts_match(tsm[0]),
    .id_value(id_v[0]), .ts_value(ts_v[0]), .retry_count(rc[0]));
  niosii_system_sysid_checker #(.WAIT_CYCLES(1), .AUTO_START(1'b0)) u1 (
    .clock(clk), .reset(reset), .start(start[1]), .sysid_address(addr[1]), .sysid_readdata(rd[1]),
    .busy(busy[1]), .done(done_o[1]), .id_match(idm[1]), .ts_match(tsm[1]),
    .id_value(id_v[1]), .ts_value(ts_v[1]), .retry_count(rc[1]));
  task automatic check_zero(input string nm);
    for (int u = 0; u < 2; u++) begin
      checks++;
      if ({addr[u], busy[u], done_o[u], idm[u], tsm[u], id_v[u], ts_v[u], rc[u]} !== 73'd0) begin
        errors++;
        $display("FAIL %s u%0d outputs got a%b b%b d%b im%b tm%b id=%h ts=%h rc=%0d want all zero",
                 nm, u, addr[u], busy[u], done_o[u], idm[u], tsm[u], id_v[u], ts_v[u], rc[u]);
      end
    end
  endtask
  task automatic kick(input int u);
    @(negedge clk);
    start[u] = 1'b1;
    @(posedge clk);
    #1 start[u] = 1'b0;
  endtask
  // inj: -1 no extra start, -2 extra start in the DONE cycle, else cycle index of the extra start
  task automatic watch(input int u, input string nm, input int inj);
    int w, per, r, total, at;
    logic ea, eb, ed, ie, te;
    w = wc[u];
    per = 2 * w + 1;
    ie = id_w[u] == 32'd0;
    te = ts_w[u] == EXP_TS;
    r = (ie && te) ? 0 : RETRY_LIM;
    total = per * (r + 1);
    at = (inj == -2) ? total : inj;
    for (int n = 0; n < total + 4; n++) begin
      @(negedge clk);
      ea = n < total && (n % per) >= w && (n % per) < 2 * w;
      eb = n < total;
      ed = n == total;
      checks++;
      if ({addr[u], busy[u], done_o[u]} !== {ea, eb, ed}) begin
        errors++;
        $display("FAIL %s u%0d cycle %0d addr/busy/done got %b%b%b want %b%b%b",
                 nm, u, n, addr[u], busy[u], done_o[u], ea, eb, ed);
      end
      checks++;
      if ({busy[1-u], done_o[1-u]} !== 2'b00) begin
        errors++;
        $display("FAIL %s idle u%0d cycle %0d busy/done got %b%b want 00", nm, 1 - u, n, busy[1-u], done_o[1-u]);
      end
      if (n == at) start[u] = 1'b1;
      if (n == at + 1) start[u] = 1'b0;
    end
    start[u] = 1'b0;
    checks++;
    if ({idm[u], tsm[u]} !== {ie, te}) begin
      errors++;
      $display("FAIL %s u%0d match got %b%b want %b%b", nm, u, idm[u], tsm[u], ie, te);
    end
    checks++;
    if (id_v[u] !== id_w[u] || ts_v[u] !== ts_w[u]) begin
      errors++;
      $display("FAIL %s u%0d values got %h/%h want %h/%h", nm, u, id_v[u], ts_v[u], id_w[u], ts_w[u]);
    end
    checks++;
    if (rc[u] !== 4'(r)) begin
      errors++;
      $display("FAIL %s u%0d retry_count got %0d want %0d", nm, u, rc[u], r);
    end
  endtask
  task automatic test_reset();
    repeat (3) @(negedge clk);
    check_zero("reset_hold");
    reset = 1'b0;
  endtask
  task automatic test_auto_start();
    watch(0, "auto_start", -1);
  endtask
  task automatic test_id_mismatch();
    id_w[0] = 32'h5;
    kick(0);
    watch(0, "id_mismatch", -1);
    id_w[0] = 32'd0;
    ts_w[0] = EXP_TS ^ 32'h8000_0000;
    kick(0);
    watch(0, "ts_mismatch", -1);
    ts_w[0] = EXP_TS;
  endtask
  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      int u;
      u = int'($urandom_range(1, 0));
      id_w[u] = $urandom_range(1, 0) ? 32'd0 : $urandom;
      ts_w[u] = $urandom_range(1, 0) ? EXP_TS : $urandom;
      kick(u);
      watch(u, "random", -1);
    end
    id_w = '{32'd0, 32'd0};
    ts_w = '{EXP_TS, EXP_TS};
  endtask
  task automatic test_start_ignored();
    kick(0);
    watch(0, "start_mid", 2);
    kick(1);
    watch(1, "start_in_done", -2);
  endtask
  task automatic test_w1_latency();
    kick(1);
    watch(1, "w1_latency", -1);
  endtask
  task automatic test_reset_mid();
    kick(0);
    for (int n = 0; n <= wc[0]; n++) @(negedge clk);
    #1 reset = 1'b1;
    #1 check_zero("reset_async");
    @(negedge clk);
    check_zero("reset_mid_hold");
    reset = 1'b0;
    watch(0, "auto_after_reset", -1);
  endtask
  initial begin
    start = '{1'b0, 1'b0};
    id_w = '{32'd0, 32'd0};
    ts_w = '{EXP_TS, EXP_TS};
    test_reset();
    test_auto_start();
    test_id_mismatch();
    test_random();
    test_start_ignored();
    test_w1_latency();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
